// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one UART transmitter between NUM_REQ requesters. Requesters are
// served round-robin. A character is handed to the transmitter only while the
// peer is ready (CTS) and the transmitter is idle. A transmitter that never
// reports busy after a start pulse raises a sticky timeout error. The timed-out
// byte is dropped and arbitration carries on.
//
// Ports
//   SysClk          system clock, all state on rising edge
//   Rst             asynchronous active-low reset
//   Req             per-requester send request (level, held until Ack)
//   Req_Data        requester i byte at [i*DATA_BITS +: DATA_BITS]
//   Ack             one-hot 1-cycle pulse: byte of requester Grant_Id accepted
//   CTS             1 = peer ready to receive (checked only when idle)
//   Tx_Data         byte presented to the transmitter, held until next grant
//   Transmit_Start  1-cycle start pulse to the transmitter
//   Tx_Busy         transmitter busy
//   Grant_Id        index of the last granted requester
//   Timeout_Err     sticky: transmitter never went busy after a start
//   Err_Clr         clears Timeout_Err (a timeout in the same cycle wins)
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int DATA_BITS     = 8,
  parameter int START_TIMEOUT = 16
) (
  input  logic                         SysClk,
  input  logic                         Rst,
  input  logic [NUM_REQ-1:0]           Req,
  input  logic [NUM_REQ*DATA_BITS-1:0] Req_Data,
  output logic [NUM_REQ-1:0]           Ack,
  input  logic                         CTS,
  output logic [DATA_BITS-1:0]         Tx_Data,
  output logic                         Transmit_Start,
  input  logic                         Tx_Busy,
  output logic [$clog2(NUM_REQ)-1:0]   Grant_Id,
  output logic                         Timeout_Err,
  input  logic                         Err_Clr
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = $clog2(START_TIMEOUT);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] LOAD      = 2'd1;
  localparam logic [1:0] WAIT_BUSY = 2'd2;
  localparam logic [1:0] WAIT_DONE = 2'd3;

  logic [1:0]           state;
  logic [1:0]           state_nxt;
  logic [CW-1:0]        wait_cnt;
  logic [GW-1:0]        winner;
  logic                 winner_valid;
  logic [DATA_BITS-1:0] winner_data;
  logic                 grant;
  logic                 timeout;

  // Index reached by stepping k places upward from base, wrapping at NUM_REQ.
  function automatic logic [GW-1:0] rr_index(input logic [GW-1:0] base, input int k);
    int sum;
    sum = (int'(base) + k) % NUM_REQ;
    return sum[GW-1:0];
  endfunction

  // Round-robin pick: first requester above the last grant. Scanning from the
  // farthest candidate down lets the nearest one overwrite, so no found-flag
  // is needed.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    winner       = Grant_Id;
    winner_valid = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (Req[rr_index(Grant_Id, k)]) begin
        winner       = rr_index(Grant_Id, k);
        winner_valid = 1'b1;
      end
    end
  end

  always_comb begin
    winner_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == GW'(i)) winner_data = Req_Data[i*DATA_BITS +: DATA_BITS];
    end
  end

  assign grant   = (state == IDLE) && CTS && !Tx_Busy && winner_valid;
  assign timeout = (state == WAIT_BUSY) && !Tx_Busy &&
                   (wait_cnt == CW'(START_TIMEOUT - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (grant) state_nxt = LOAD;
      LOAD:      state_nxt = WAIT_BUSY;
      // Busy is checked before the timeout so a transmitter answering in the
      // last allowed cycle is still accepted.
      WAIT_BUSY: if (Tx_Busy) state_nxt = WAIT_DONE;
                 else if (timeout) state_nxt = IDLE;
      WAIT_DONE: if (!Tx_Busy) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge SysClk or negedge Rst) begin
    if (!Rst) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      Grant_Id    <= GW'(NUM_REQ - 1);
      Tx_Data     <= '0;
      Timeout_Err <= 1'b0;
    end else begin
      state <= state_nxt;

      if (state == WAIT_BUSY && !Tx_Busy && !timeout) wait_cnt <= wait_cnt + 1'b1;
      else                                            wait_cnt <= '0;

      if (grant) begin
        Grant_Id <= winner;
        Tx_Data  <= winner_data;
      end

      if (timeout)      Timeout_Err <= 1'b1;
      else if (Err_Clr) Timeout_Err <= 1'b0;
    end
  end

  // Start and Ack are pure decodes of LOAD, so an asynchronous reset removes
  // them immediately and no other state can ever pulse them.
  assign Transmit_Start = (state == LOAD);

  always_comb begin
    Ack = '0;
    if (state == LOAD) Ack[Grant_Id] = 1'b1;
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Self-checking bench for uart_tx_arbiter (NUM_REQ=4, DATA_BITS=8,
// START_TIMEOUT=16). Directed table vectors, hand-written flow-control,
// timeout and reset sequences, and a randomized run against a timeline model
// of the arbiter's behaviour. Inputs change 1 time unit after the rising edge.
// Outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int TO = 16;

  logic          SysClk = 1'b0;
  logic          Rst;
  logic [N-1:0]  Req;
  logic [N*DW-1:0] Req_Data;
  logic [N-1:0]  Ack;
  logic          CTS;
  logic [DW-1:0] Tx_Data;
  logic          Transmit_Start;
  logic          Tx_Busy;
  logic [1:0]    Grant_Id;
  logic          Timeout_Err;
  logic          Err_Clr;

  int n_checks = 0;
  int n_pass   = 0;

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_BITS(DW), .START_TIMEOUT(TO)) dut (
    .SysClk(SysClk), .Rst(Rst), .Req(Req), .Req_Data(Req_Data), .Ack(Ack),
    .CTS(CTS), .Tx_Data(Tx_Data), .Transmit_Start(Transmit_Start),
    .Tx_Busy(Tx_Busy), .Grant_Id(Grant_Id), .Timeout_Err(Timeout_Err),
    .Err_Clr(Err_Clr)
  );

  always #5 SysClk = ~SysClk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic next_cycle();
    @(posedge SysClk);
    #1;
  endtask

  // Finish a character from its LOAD cycle: transmitter busy for two cycles,
  // returns at the first IDLE cycle.
  task automatic serve();
    next_cycle(); Req = '0; Tx_Busy = 1'b1;
    next_cycle();
    next_cycle(); Tx_Busy = 1'b0;
    next_cycle();
  endtask

  function automatic int rr_pick(input int last, input logic [N-1:0] r);
    int j;
    for (int k = 1; k <= N; k++) begin
      j = (last + k) % N;
      if (r[j[1:0]]) return j;
    end
    return last;
  endfunction

  typedef struct {
    logic [N-1:0]    req;
    logic [N*DW-1:0] data;
    logic            cts;
    logic            busy;
    logic            exp_start;
    logic [N-1:0]    exp_ack;
    logic [1:0]      exp_grant;
    logic [DW-1:0]   exp_tx;
  } vec_t;

  vec_t vecs[10];

  // Random-phase model and stimulus state
  logic [DW-1:0] bytes[N];
  logic [N-1:0]  rq, prev_ack, e_ack;
  logic          e_start, e_err, busy_now, cts_r, eclr_r;
  logic [DW-1:0] e_tx;
  int            e_grant, idle_from, to_end, busy_on, busy_off, d, w;
  logic          seen;

  initial begin
    Rst = 1'b0; Req = '0; Req_Data = '0; CTS = 1'b0; Tx_Busy = 1'b0; Err_Clr = 1'b0;

    //        req      data          cts  busy start ack      grant tx
    vecs[0] = '{4'b0100, 32'h00A5_0000, 1, 0, 1, 4'b0100, 2'd2, 8'hA5};
    vecs[1] = '{4'b1111, 32'h1312_1110, 1, 0, 1, 4'b1000, 2'd3, 8'h13};
    vecs[2] = '{4'b1111, 32'h1312_1110, 1, 0, 1, 4'b0001, 2'd0, 8'h10};
    vecs[3] = '{4'b0000, 32'h0000_0000, 1, 0, 0, 4'b0000, 2'd0, 8'h10};
    vecs[4] = '{4'b1010, 32'hDEAD_BEEF, 0, 0, 0, 4'b0000, 2'd0, 8'h10};
    vecs[5] = '{4'b1010, 32'hDEAD_BEEF, 1, 1, 0, 4'b0000, 2'd0, 8'h10};
    vecs[6] = '{4'b1010, 32'hDEAD_BEEF, 1, 0, 1, 4'b0010, 2'd1, 8'hBE};
    vecs[7] = '{4'b1001, 32'hCAFE_F00D, 1, 0, 1, 4'b1000, 2'd3, 8'hCA};
    vecs[8] = '{4'b0001, 32'hCAFE_F00D, 1, 0, 1, 4'b0001, 2'd0, 8'h0D};
    vecs[9] = '{4'b0001, 32'h0000_0077, 1, 0, 1, 4'b0001, 2'd0, 8'h77};

    // Reset values
    #12;
    check("rst_start", 32'(Transmit_Start), 0);
    check("rst_ack",   32'(Ack), 0);
    check("rst_tx",    32'(Tx_Data), 0);
    check("rst_grant", 32'(Grant_Id), 3);
    check("rst_err",   32'(Timeout_Err), 0);
    next_cycle(); Rst = 1'b1;
    next_cycle();

    // Directed single-character vectors; grant pointer carries over
    for (int i = 0; i < 10; i++) begin
      Req = vecs[i].req; Req_Data = vecs[i].data; CTS = vecs[i].cts; Tx_Busy = vecs[i].busy;
      next_cycle();
      if (!vecs[i].exp_start) Req = '0;
      Tx_Busy = 1'b0;
      @(negedge SysClk);
      check($sformatf("vec%0d_start", i), 32'(Transmit_Start), 32'(vecs[i].exp_start));
      check($sformatf("vec%0d_ack", i),   32'(Ack),            32'(vecs[i].exp_ack));
      check($sformatf("vec%0d_grant", i), 32'(Grant_Id),       32'(vecs[i].exp_grant));
      check($sformatf("vec%0d_tx", i),    32'(Tx_Data),        32'(vecs[i].exp_tx));
      if (vecs[i].exp_start) serve();
      else next_cycle();
    end

    // Flow control: CTS low holds off, CTS dropping mid-character is ignored
    Req = 4'b0001; Req_Data = 32'h0000_0042; CTS = 1'b0; seen = 1'b0;
    repeat (50) begin
      @(negedge SysClk);
      if (Transmit_Start) seen = 1'b1;
      next_cycle();
    end
    check("cts_hold_off", 32'(seen), 0);
    CTS = 1'b1;
    @(negedge SysClk);
    check("cts_no_early_start", 32'(Transmit_Start), 0);
    next_cycle();
    @(negedge SysClk);
    check("cts_start", 32'(Transmit_Start), 1);
    check("cts_ack",   32'(Ack), 32'b0001);
    check("cts_tx",    32'(Tx_Data), 32'h42);
    next_cycle(); Req = '0; Tx_Busy = 1'b1;
    next_cycle(); CTS = 1'b0;
    next_cycle();
    next_cycle(); Tx_Busy = 1'b0;
    next_cycle(); CTS = 1'b1; Req = 4'b0010; Req_Data = 32'h0000_4300;
    @(negedge SysClk);
    check("cts_drop_no_err", 32'(Timeout_Err), 0);
    next_cycle();
    @(negedge SysClk);
    check("cts_drop_completes_start", 32'(Transmit_Start), 1);
    check("cts_drop_completes_ack",   32'(Ack), 32'b0010);
    serve();

    // Timeout: transmitter never goes busy
    Req = 4'b0100; Req_Data = 32'h0055_0000;
    next_cycle();
    @(negedge SysClk);
    check("to_start", 32'(Transmit_Start), 1);
    next_cycle(); Req = '0;
    repeat (15) next_cycle();
    @(negedge SysClk);
    check("to_not_early", 32'(Timeout_Err), 0);
    next_cycle(); Req = 4'b1000; Req_Data = 32'h6600_0000;
    @(negedge SysClk);
    check("to_set",        32'(Timeout_Err), 1);
    check("to_idle_start", 32'(Transmit_Start), 0);
    next_cycle();
    @(negedge SysClk);
    check("to_next_start", 32'(Transmit_Start), 1);
    check("to_next_ack",   32'(Ack), 32'b1000);
    check("to_next_tx",    32'(Tx_Data), 32'h66);
    serve();
    Err_Clr = 1'b1;
    @(negedge SysClk);
    check("to_sticky", 32'(Timeout_Err), 1);
    next_cycle(); Err_Clr = 1'b0;
    @(negedge SysClk);
    check("to_cleared", 32'(Timeout_Err), 0);

    // Timeout and Err_Clr in the same cycle: set wins
    Req = 4'b0001; Req_Data = 32'h0000_0077;
    next_cycle();
    @(negedge SysClk);
    check("to2_grant", 32'(Grant_Id), 0);
    next_cycle(); Req = '0;
    repeat (15) next_cycle();
    Err_Clr = 1'b1;
    next_cycle(); Err_Clr = 1'b0;
    @(negedge SysClk);
    check("to2_set_wins", 32'(Timeout_Err), 1);

    // Asynchronous reset during WAIT_DONE
    next_cycle(); Req = 4'b0010; Req_Data = 32'h0000_9900;
    next_cycle();
    @(negedge SysClk);
    check("mid_rst_start", 32'(Transmit_Start), 1);
    next_cycle(); Req = '0; Tx_Busy = 1'b1;
    next_cycle();
    next_cycle();
    #2 Rst = 1'b0;
    #1;
    check("mid_rst_start_low", 32'(Transmit_Start), 0);
    check("mid_rst_ack",       32'(Ack), 0);
    check("mid_rst_tx",        32'(Tx_Data), 0);
    check("mid_rst_grant",     32'(Grant_Id), 3);
    check("mid_rst_err",       32'(Timeout_Err), 0);
    Tx_Busy = 1'b0; Req = 4'b0011; Req_Data = 32'h0000_BBAA;
    @(negedge SysClk); Rst = 1'b1;
    next_cycle();
    @(negedge SysClk);
    check("post_rst_start", 32'(Transmit_Start), 1);
    check("post_rst_ack",   32'(Ack), 32'b0001);
    check("post_rst_grant", 32'(Grant_Id), 0);
    check("post_rst_tx",    32'(Tx_Data), 32'hAA);
    serve();

    // Randomized run against a timeline model
    Rst = 1'b0;
    next_cycle(); Rst = 1'b1;
    rq = '0; prev_ack = '0; e_ack = '0; e_start = 1'b0; e_err = 1'b0; e_tx = '0;
    e_grant = N - 1; idle_from = 0; to_end = -1; busy_on = -1; busy_off = -1;
    for (int i = 0; i < N; i++) bytes[i] = '0;

    for (int c = 0; c < 3000; c++) begin
      next_cycle();
      for (int i = 0; i < N; i++) begin
        if (prev_ack[i]) begin
          rq[i] = 1'($urandom_range(0, 1));
          bytes[i] = 8'($urandom);
        end else if (rq[i]) begin
          if (!e_ack[i] && $urandom_range(0, 15) == 0) rq[i] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          rq[i] = 1'b1;
          bytes[i] = 8'($urandom);
        end
      end
      cts_r    = ($urandom_range(0, 3) != 0);
      eclr_r   = ($urandom_range(0, 9) == 0);
      busy_now = (c >= busy_on) && (c < busy_off);
      Req = rq; Req_Data = {bytes[3], bytes[2], bytes[1], bytes[0]};
      CTS = cts_r; Err_Clr = eclr_r; Tx_Busy = busy_now;

      @(negedge SysClk);
      check("rnd_start", 32'(Transmit_Start), 32'(e_start));
      check("rnd_ack",   32'(Ack),            32'(e_ack));
      check("rnd_grant", 32'(Grant_Id),       32'(e_grant));
      check("rnd_tx",    32'(Tx_Data),        32'(e_tx));
      check("rnd_err",   32'(Timeout_Err),    32'(e_err));

      // Expected outputs for cycle c+1
      prev_ack = e_ack;
      if (c == to_end) e_err = 1'b1;
      else if (eclr_r) e_err = 1'b0;

      if (e_start) begin
        // Character started in cycle c: choose how the transmitter responds
        if ($urandom_range(0, 4) == 0) begin
          to_end    = c + TO;
          idle_from = c + TO + 1;
          busy_on   = -1;
          busy_off  = -1;
        end else begin
          d         = $urandom_range(1, TO);
          busy_on   = c + d;
          busy_off  = c + d + $urandom_range(1, 6);
          idle_from = busy_off + 1;
        end
      end

      if (c >= idle_from && cts_r && !busy_now && rq != '0) begin
        w       = rr_pick(e_grant, rq);
        e_start = 1'b1;
        e_ack   = 4'b0001 << w;
        e_grant = w;
        e_tx    = bytes[w];
      end else begin
        e_start = 1'b0;
        e_ack   = '0;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameters SHALL be, one per line:
  NUM_REQ, 4, number of requesters sharing the UART transmitter (2..8)
  DATA_BITS, 8, character width; matches the UART transmitter
  START_TIMEOUT, 16, max cycles from Transmit_Start to Tx_Busy rising (>=2)
REQ-002 Ports SHALL be, one per line:
  SysClk  in  1  system clock, all state on rising edge
  Rst  in  1  asynchronous active-low reset
  Req  in  NUM_REQ  per-requester send request, level
  Req_Data  in  NUM_REQ*DATA_BITS  requester i byte at [i*DATA_BITS +: DATA_BITS]
  Ack  out  NUM_REQ  one-hot, 1-cycle pulse: byte of requester i accepted
  CTS  in  1  1 = peer ready to receive
  Tx_Data  out  DATA_BITS  byte presented to the UART transmitter
  Transmit_Start  out  1  1-cycle start pulse to the UART transmitter
  Tx_Busy  in  1  UART transmitter busy
  Grant_Id  out  $clog2(NUM_REQ)  index of last granted requester
  Timeout_Err  out  1  sticky: transmitter never went busy
  Err_Clr  in  1  clears Timeout_Err
REQ-003 The clock SHALL be SysClk only; Rst SHALL be asynchronous, active-low.

Function
REQ-004 FSM states SHALL be IDLE, LOAD, WAIT_BUSY, WAIT_DONE.
REQ-005 IDLE -> LOAD when CTS=1, Tx_Busy=0 and any Req bit=1; otherwise stay in IDLE.
REQ-006 Winner SHALL be chosen round-robin: first set Req bit scanning upward from Grant_Id+1, wrapping NUM_REQ-1 -> 0; Grant_Id updated on the IDLE->LOAD edge.
REQ-007 On the IDLE->LOAD edge Tx_Data SHALL register Req_Data of the winner; Tx_Data holds until the next grant.
REQ-008 In LOAD (exactly 1 cycle): Transmit_Start=1, Ack[Grant_Id]=1, all other Ack bits 0; next state WAIT_BUSY.
REQ-009 Latency: Req sampled in IDLE at edge n -> Transmit_Start and Ack high during cycle n+1.
REQ-010 WAIT_BUSY: a counter counts cycles; Tx_Busy=1 -> WAIT_DONE; counter reaching START_TIMEOUT with Tx_Busy=0 -> set Timeout_Err, go IDLE.
REQ-011 WAIT_DONE: remain while Tx_Busy=1; Tx_Busy=0 -> IDLE. No timeout in WAIT_DONE.
REQ-012 CTS SHALL be checked only in IDLE; CTS falling after LOAD does not abort the character in flight.
REQ-013 Requester i SHALL hold Req[i] and its Req_Data stable until Ack[i]; dropping Req before Ack is legal, and the request is simply not granted.
REQ-014 Ack SHALL never pulse for a requester whose Req was 0 at grant time.
REQ-015 Transmit_Start and Ack SHALL be 0 in every state except LOAD.
REQ-016 Back-to-back: a requester holding Req after Ack is re-granted only after all other pending requesters are served.
REQ-017 Timeout_Err SHALL stay 1 until Err_Clr=1 is sampled; simultaneous set and Err_Clr in the same cycle SHALL leave Timeout_Err=1.
REQ-018 Timeout does not block arbitration; the timed-out byte is dropped (already Acked).

Reset
REQ-019 Rst=0 SHALL immediately force: state IDLE, Transmit_Start=0, Ack=0, Tx_Data=0, Grant_Id=NUM_REQ-1 (so requester 0 wins first), timeout counter 0, Timeout_Err=0.
REQ-020 Rst asserted mid-transfer SHALL abandon the transfer without an Ack or Transmit_Start pulse; after release the FSM starts in IDLE.

Verification
REQ-021 Single: Req=4'b0100, Req_Data[2]=8'hA5, CTS=1 -> one cycle later Transmit_Start=1, Ack=4'b0100, Tx_Data=8'hA5, Grant_Id=2.
REQ-022 Round-robin: Req=4'b1111 held, bytes 8'h10/8'h11/8'h12/8'h13, UART model busy 10 cycles each -> grant order 0,1,2,3,0; exactly one Ack per character.
REQ-023 Flow control: CTS=0 with Req=4'b0001 for 50 cycles -> no Transmit_Start; CTS->1 -> Transmit_Start 1 cycle after the sampling edge; CTS->0 during WAIT_DONE -> character completes.
REQ-024 Timeout: Tx_Busy held 0 after Transmit_Start -> Timeout_Err=1 after 16 cycles in WAIT_BUSY, FSM in IDLE; the next Req is granted; Err_Clr=1 -> Timeout_Err=0.
REQ-025 Reset mid-operation: Rst=0 during WAIT_DONE -> all outputs at reset values asynchronously; after release, Req=4'b0011 -> requester 0 granted first.
